// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU.
// Issues one op, waits a cycle for the result, then holds it for the consumer.
module alu_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int W         = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         last_q;
  logic         owner_q;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic         rsp_id_q;
  logic [W-1:0] rsp_res_q;
  logic         rsp_zero_q;
  logic         rsp_err_q;

  logic         tie_pick;
  logic         pick;
  logic         open;
  logic         xfer;
  logic [2:0]   sel_op;
  logic [W-1:0] sel_a, sel_b;
  logic         illegal;

  // Ties go to the requester not served last, or always to 0 in fixed mode.
  always_comb begin
    tie_pick = (PRIO_MODE != 0) ? 1'b0 : ~last_q;
    pick     = tie_pick;
    unique case (1'b1)
      req0_valid && !req1_valid: pick = 1'b0;
      req1_valid && !req0_valid: pick = 1'b1;
      default:                   pick = tie_pick;
    endcase
  end

  always_comb begin
    open       = (state_q == IDLE) ||
                 ((state_q == RESP) && rsp_ready);
    req0_ready = open && !pick;
    req1_ready = open && pick;
    xfer       = pick ? (open && req1_valid)
                      : (open && req0_valid);
    sel_op     = pick ? req1_op : req0_op;
    sel_a      = pick ? req1_a  : req0_a;
    sel_b      = pick ? req1_b  : req0_b;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (xfer) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = xfer ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign illegal = op_q[2] && op_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id_q   <= 1'b0;
      rsp_res_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        op_q    <= sel_op;
        a_q     <= sel_a;
        b_q     <= sel_b;
        owner_q <= pick;
        last_q  <= pick;
      end
      // Illegal ops still reach the ALU; its answer is masked here.
      if (state_q == EXEC) begin
        rsp_id_q   <= owner_q;
        rsp_res_q  <= illegal ? '0 : alu_result;
        rsp_zero_q <= illegal ? 1'b1 : alu_zero;
        rsp_err_q  <= illegal;
      end
    end
  end

  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_res_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances
// share stimulus; each has its own ALU model and response queue.
module tb_alu_arbiter;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;

  logic [1:0]       rdy0, rdy1, rv, rid, rz, rerr, azero;
  logic [1:0][2:0]  aop;
  logic [1:0][15:0] aa, ab, ares, rres;

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_f(
    input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = {15'd0, a == b};
      3'd5:    r = {15'd0, a <= b};
      default: r = 16'hBEEF;
    endcase
    return {1'b0, r} | {(op < 3'd6) && (r == 16'd0), 16'd0};
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++)
      {azero[i], ares[i]} = alu_f(aop[i], aa[i], ab[i]);
  end

  alu_arbiter #(.PRIO_MODE(0), .W(16)) dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ready(rdy0[0]),
    .req1_valid(req1_valid), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ready(rdy1[0]),
    .alu_op(aop[0]), .alu_a(aa[0]), .alu_b(ab[0]),
    .alu_result(ares[0]), .alu_zero(azero[0]),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]),
    .rsp_result(rres[0]), .rsp_zero(rz[0]), .rsp_err(rerr[0])
  );

  alu_arbiter #(.PRIO_MODE(1), .W(16)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ready(rdy0[1]),
    .req1_valid(req1_valid), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ready(rdy1[1]),
    .alu_op(aop[1]), .alu_a(aa[1]), .alu_b(ab[1]),
    .alu_result(ares[1]), .alu_zero(azero[1]),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]),
    .rsp_result(rres[1]), .rsp_zero(rz[1]), .rsp_err(rerr[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb0.delete();
    sb1.delete();
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0009; req0_b = 16'h0009;
    step();
    step();
    rst = 1'b0;
    req0_valid = 1'b0;
    sb0.delete();
    sb1.delete();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({aop[i], aa[i], ab[i], rv[i], rid[i], rres[i], rz[i], rerr[i]} !== '0)
        $display("FAIL reset_outs[%0d] got op=%0d a=%h b=%h v=%b id=%b r=%h z=%b e=%b want all 0",
                 i, aop[i], aa[i], ab[i], rv[i], rid[i], rres[i], rz[i], rerr[i]);
      else n_pass++;
      n_chk++;
      if ({rdy1[i], rdy0[i]} !== 2'b01)
        $display("FAIL reset_ready[%0d] got %b want 01", i, {rdy1[i], rdy0[i]});
      else n_pass++;
    end
  endtask

  task automatic test_add();
    exp_t got, e;
    do_reset();
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0003; req0_b = 16'h0004;
    @(negedge clk);
    n_chk++;
    if (rdy0[0] !== 1'b1) $display("FAIL add_ready got %b want 1", rdy0[0]);
    else n_pass++;
    sb0.push_back({1'b0, 16'h0007, 1'b0, 1'b0});
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({aop[0], aa[0], ab[0], rv[0]} !== {3'd0, 16'h0003, 16'h0004, 1'b0})
      $display("FAIL add_issue got op=%0d a=%h b=%h v=%b want 0/0003/0004/0",
               aop[0], aa[0], ab[0], rv[0]);
    else n_pass++;
    step();
    @(negedge clk);
    n_chk++;
    if (rv[0] !== 1'b1) $display("FAIL add_latency got %b want 1", rv[0]);
    else n_pass++;
    got = {rid[0], rres[0], rz[0], rerr[0]};
    n_chk++;
    if (sb0.size() == 0) $display("FAIL add_rsp queue empty");
    else begin
      e = sb0.pop_front();
      if (got !== e) $display("FAIL add_rsp got %h want %h", got, e);
      else n_pass++;
    end
    step();
    @(negedge clk);
    n_chk++;
    if (rv[0] !== 1'b0) $display("FAIL add_drain got %b want 0", rv[0]);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    exp_t got, e;
    logic g;
    logic [1:0] x0, x1;
    do_reset();
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0010; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 16'h0020; req1_b = 16'h0001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      x0 = 2'b00;
      x1 = 2'b00;
      if (k % 2 == 0) begin
        g  = ((k / 2) % 2) == 1;
        x0 = g ? 2'b10 : 2'b01;
        x1 = 2'b01;
      end
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if ({rdy1[i], rdy0[i]} !== (i == 0 ? x0 : x1))
          $display("FAIL rr_ready[%0d] cyc %0d got %b want %b",
                   i, k, {rdy1[i], rdy0[i]}, (i == 0 ? x0 : x1));
        else n_pass++;
        n_chk++;
        if (rv[i] !== (k % 2 == 0 && k >= 2))
          $display("FAIL rr_valid[%0d] cyc %0d got %b want %b",
                   i, k, rv[i], (k % 2 == 0 && k >= 2));
        else n_pass++;
      end
      if (k % 2 == 0 && k >= 2) begin
        got = {rid[0], rres[0], rz[0], rerr[0]};
        n_chk++;
        if (sb0.size() == 0) $display("FAIL rr_rsp0 cyc %0d queue empty", k);
        else begin
          e = sb0.pop_front();
          if (got !== e) $display("FAIL rr_rsp0 cyc %0d got %h want %h", k, got, e);
          else n_pass++;
        end
        got = {rid[1], rres[1], rz[1], rerr[1]};
        n_chk++;
        if (sb1.size() == 0) $display("FAIL rr_rsp1 cyc %0d queue empty", k);
        else begin
          e = sb1.pop_front();
          if (got !== e) $display("FAIL rr_rsp1 cyc %0d got %h want %h", k, got, e);
          else n_pass++;
        end
      end
      if (k % 2 == 0) begin
        sb0.push_back(g ? {1'b1, 16'h001F, 1'b0, 1'b0}
                        : {1'b0, 16'h0011, 1'b0, 1'b0});
        sb1.push_back({1'b0, 16'h0011, 1'b0, 1'b0});
      end
      step();
    end
    set_idle();
  endtask

  task automatic test_compare();
    exp_t got, e;
    logic [2:0]  op_t [2] = '{3'd1, 3'd5};
    logic [15:0] a_t  [2] = '{16'h0005, 16'h0002};
    logic [15:0] b_t  [2] = '{16'h0005, 16'h0009};
    exp_t        e_t  [2] = '{{1'b1, 16'h0000, 1'b1, 1'b0},
                              {1'b1, 16'h0001, 1'b0, 1'b0}};
    int c;
    do_reset();
    for (int j = 0; j < 2; j++) begin
      req1_valid = 1'b1; req1_op = op_t[j]; req1_a = a_t[j]; req1_b = b_t[j];
      c = 0;
      @(negedge clk);
      while (!rdy1[0] && c < 4) begin
        step();
        @(negedge clk);
        c++;
      end
      n_chk++;
      if (rdy1[0] !== 1'b1) $display("FAIL cmp_grant[%0d] got %b want 1", j, rdy1[0]);
      else n_pass++;
      sb0.push_back(e_t[j]);
      step();
      req1_valid = 1'b0;
      c = 1;
      @(negedge clk);
      while (!rv[0] && c < 5) begin
        step();
        @(negedge clk);
        c++;
      end
      n_chk++;
      if (c !== 2 || rv[0] !== 1'b1)
        $display("FAIL cmp_latency[%0d] got %0d cycles v=%b want 2 cycles v=1", j, c, rv[0]);
      else n_pass++;
      got = {rid[0], rres[0], rz[0], rerr[0]};
      n_chk++;
      if (sb0.size() == 0) $display("FAIL cmp_rsp[%0d] queue empty", j);
      else begin
        e = sb0.pop_front();
        if (got !== e) $display("FAIL cmp_rsp[%0d] got %h want %h", j, got, e);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, e;
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0001; req0_b = 16'h0001;
    @(negedge clk);
    sb0.push_back({1'b0, 16'h0002, 1'b0, 1'b0});
    step();
    req0_a = 16'h0002; req0_b = 16'h0002;
    step();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      got = {rid[0], rres[0], rz[0], rerr[0]};
      n_chk++;
      if ({rv[0], rdy0[0], got} !== {1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0})
        $display("FAIL stall cyc %0d got v=%b rdy=%b rsp=%h want v=1 rdy=0 rsp=%h",
                 s, rv[0], rdy0[0], got, {1'b0, 16'h0002, 1'b0, 1'b0});
      else n_pass++;
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({rv[0], rdy0[0]} !== 2'b11)
      $display("FAIL release got v=%b rdy=%b want 1/1", rv[0], rdy0[0]);
    else n_pass++;
    got = {rid[0], rres[0], rz[0], rerr[0]};
    n_chk++;
    if (sb0.size() == 0) $display("FAIL release_rsp queue empty");
    else begin
      e = sb0.pop_front();
      if (got !== e) $display("FAIL release_rsp got %h want %h", got, e);
      else n_pass++;
    end
    sb0.push_back({1'b0, 16'h0004, 1'b0, 1'b0});
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({rv[0], aa[0]} !== {1'b0, 16'h0002})
      $display("FAIL b2b_issue got v=%b a=%h want 0/0002", rv[0], aa[0]);
    else n_pass++;
    step();
    @(negedge clk);
    got = {rid[0], rres[0], rz[0], rerr[0]};
    n_chk++;
    if (rv[0] !== 1'b1 || sb0.size() == 0)
      $display("FAIL b2b_rsp got v=%b queued=%0d want v=1 queued=1", rv[0], sb0.size());
    else begin
      e = sb0.pop_front();
      if (got !== e) $display("FAIL b2b_rsp got %h want %h", got, e);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_illegal_reset();
    exp_t got, e;
    do_reset();
    req0_valid = 1'b1; req0_op = 3'd7; req0_a = 16'h0005; req0_b = 16'h0006;
    @(negedge clk);
    sb0.push_back({1'b0, 16'h0000, 1'b1, 1'b1});
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (aop[0] !== 3'd7) $display("FAIL ill_issue got op=%0d want 7", aop[0]);
    else n_pass++;
    step();
    @(negedge clk);
    got = {rid[0], rres[0], rz[0], rerr[0]};
    n_chk++;
    if (rv[0] !== 1'b1 || sb0.size() == 0)
      $display("FAIL ill_rsp got v=%b queued=%0d want v=1 queued=1", rv[0], sb0.size());
    else begin
      e = sb0.pop_front();
      if (got !== e) $display("FAIL ill_rsp got %h want %h", got, e);
      else n_pass++;
    end
    step();
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0001; req0_b = 16'h0002;
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb0.delete();
    sb1.delete();
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      n_chk++;
      if ({aop[0], aa[0], ab[0], rv[0], rid[0], rres[0], rz[0], rerr[0]} !== '0)
        $display("FAIL flush cyc %0d got op=%0d a=%h b=%h v=%b id=%b r=%h z=%b e=%b want all 0",
                 s, aop[0], aa[0], ab[0], rv[0], rid[0], rres[0], rz[0], rerr[0]);
      else n_pass++;
      step();
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({rdy1[0], rdy0[0]} !== 2'b01)
      $display("FAIL tie_after_reset got %b want 01", {rdy1[0], rdy0[0]});
    else n_pass++;
    step();
    set_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_add();
    test_round_robin();
    test_compare();
    test_back_to_back();
    test_illegal_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
